// File: rtl/apb_timer_slave.sv
// ---------------------------------------------------------------------------
// apb_timer_slave
//
// APB slave holding a prescaled down-counter timer. Every register access
// takes one wait state: setup cycle, access cycle, one wait cycle, then a
// single DONE cycle in which pready is high, prdata/pslverr are valid and
// any write commits at the closing clock edge.
//
// Register map (paddr[1:0], upper address bits must be zero):
//   0 CTRL   : [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN, [3+:PRE_W] PRESCALE
//   1 LOAD   : reload value
//   2 COUNT  : current count, read-only (writes complete but are dropped)
//   3 STATUS : [0] EXPIRED, sticky, write 1 to clear
//
// Handshake: a transfer starts with psel=1/penable=0 (setup), continues with
// psel=1/penable=1 (access) and completes when pready=1, which lasts exactly
// one cycle. Dropping psel before pready abandons the transfer without any
// register side effect and without a pready pulse.
//
// Ports:
//   pclk     in   APB clock, single clock domain
//   presetn  in   synchronous active-low reset
//   psel     in   slave select
//   penable  in   access phase
//   pwrite   in   1 = write, 0 = read
//   paddr    in   register address (ADDR_W)
//   pwdata   in   write data (DATA_W)
//   prdata   out  read data, valid while pready=1, held otherwise
//   pready   out  transfer complete, one-cycle pulse
//   pslverr  out  error response for an invalid address, only with pready
//   irq      out  registered STATUS.EXPIRED & CTRL.IRQ_EN
//   tick     out  one-cycle pulse per prescaled count event
// ---------------------------------------------------------------------------
module apb_timer_slave #(
    parameter int DATA_W = 21,
    parameter int ADDR_W = 8,
    parameter int PRE_W  = 8
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              irq,
    output logic              tick
);

    localparam int CTRL_W = 3 + PRE_W;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LOAD   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WAIT,
        DONE
    } state_t;

    state_t state;

    // Transfer attributes captured when the access phase is accepted
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              write_q;

    // Programmer-visible state
    logic              en;
    logic              auto_reload;
    logic              irq_en;
    logic [PRE_W-1:0]  prescale;
    logic [DATA_W-1:0] load;
    logic [DATA_W-1:0] count;
    logic              expired;

    // Timer internals
    logic [PRE_W-1:0]  pre_cnt;

    // -----------------------------------------------------------------------
    // Decode of the captured transfer
    // -----------------------------------------------------------------------
    logic              addr_err;
    logic [1:0]        reg_sel;
    logic              commit;
    logic              wr_ctrl;
    logic              wr_load;
    logic              wr_status;
    logic              count_event;
    logic [DATA_W-1:0] rdata;

    assign addr_err  = (addr_q[ADDR_W-1:2] != '0);
    assign reg_sel   = addr_q[1:0];
    assign commit    = (state == DONE) && write_q && !addr_err;
    assign wr_ctrl   = commit && (reg_sel == REG_CTRL);
    assign wr_load   = commit && (reg_sel == REG_LOAD);
    assign wr_status = commit && (reg_sel == REG_STATUS);

    // ">=" rather than "==" so that lowering PRESCALE below the running
    // prescale count produces an event right away instead of a wrap-around.
    assign count_event = en && (pre_cnt >= prescale);

    always_comb begin
        rdata = '0;
        if (!addr_err) begin
            case (reg_sel)
                REG_CTRL:   rdata[CTRL_W-1:0] = {prescale, irq_en, auto_reload, en};
                REG_LOAD:   rdata = load;
                REG_COUNT:  rdata = count;
                REG_STATUS: rdata[0] = expired;
                default:    rdata = '0;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // APB transfer FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            prdata  <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
        end else begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            case (state)
                IDLE: begin
                    if (psel && !penable) begin
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (!psel) begin
                        state <= IDLE;
                    end else if (penable) begin
                        state   <= WAIT;
                        addr_q  <= paddr;
                        wdata_q <= pwdata;
                        write_q <= pwrite;
                    end
                end
                WAIT: begin
                    if (!psel) begin
                        // Master gave up: no response, nothing committed
                        state <= IDLE;
                    end else begin
                        state   <= DONE;
                        pready  <= 1'b1;
                        pslverr <= addr_err;
                        prdata  <= rdata;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Registers and timer
    //
    // Statement order sets precedence inside the clock edge:
    //   STATUS clear  <  expiry          (a coincident expiry keeps EXPIRED)
    //   auto-disable  <  CTRL write      (software value of EN wins)
    // -----------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            en          <= 1'b0;
            auto_reload <= 1'b0;
            irq_en      <= 1'b0;
            prescale    <= '0;
            load        <= '0;
            count       <= '0;
            expired     <= 1'b0;
            pre_cnt     <= '0;
            tick        <= 1'b0;
            irq         <= 1'b0;
        end else begin
            tick <= 1'b0;

            if (wr_status && wdata_q[0]) begin
                expired <= 1'b0;
            end

            if (en) begin
                if (count_event) begin
                    pre_cnt <= '0;
                    tick    <= 1'b1;
                    if (count != '0) begin
                        count <= count - DATA_W'(1);
                    end else begin
                        expired <= 1'b1;
                        if (auto_reload) begin
                            count <= load;
                        end else begin
                            en <= 1'b0;
                        end
                    end
                end else begin
                    pre_cnt <= pre_cnt + PRE_W'(1);
                end
            end

            if (wr_ctrl) begin
                en          <= wdata_q[0];
                auto_reload <= wdata_q[1];
                irq_en      <= wdata_q[2];
                prescale    <= wdata_q[3 +: PRE_W];
                // Starting the timer begins a fresh period from LOAD
                if (wdata_q[0] && !en) begin
                    count   <= load;
                    pre_cnt <= '0;
                end
            end

            if (wr_load) begin
                load <= wdata_q;
                // A running timer only picks LOAD up at its next reload
                if (!en) begin
                    count <= wdata_q;
                end
            end

            irq <= expired & irq_en;
        end
    end

endmodule

// File: tb/tb_apb_timer_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_timer_slave
//
// Directed bench for apb_timer_slave. A free-running posedge counter (cyc)
// gives absolute edge numbers so timer events can be predicted relative to
// the edge on which a CTRL write commits. Transfers commit on the 4th edge
// after the task starts (task always starts just after an edge).
// ---------------------------------------------------------------------------
module tb_apb_timer_slave;

    localparam int DATA_W = 21;
    localparam int ADDR_W = 8;
    localparam int PRE_W  = 8;

    logic              pclk    = 1'b0;
    logic              presetn = 1'b0;
    logic              psel    = 1'b0;
    logic              penable = 1'b0;
    logic              pwrite  = 1'b0;
    logic [ADDR_W-1:0] paddr   = '0;
    logic [DATA_W-1:0] pwdata  = '0;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;
    logic              irq;
    logic              tick;

    int tests    = 0;
    int fails    = 0;
    int cyc      = 0;
    int tick_cnt = 0;

    apb_timer_slave #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .PRE_W (PRE_W)
    ) dut (
        .pclk   (pclk),
        .presetn(presetn),
        .psel   (psel),
        .penable(penable),
        .pwrite (pwrite),
        .paddr  (paddr),
        .pwdata (pwdata),
        .prdata (prdata),
        .pready (pready),
        .pslverr(pslverr),
        .irq    (irq),
        .tick   (tick)
    );

    // ---------------- clock / reset support ----------------
    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    always @(negedge pclk) begin
        if (tick) tick_cnt <= tick_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after posedge number t
    task automatic wait_to(input int t);
        while (cyc < t) begin
            @(posedge pclk);
            #1;
        end
    endtask

    // ---------------- driver tasks ----------------
    // Call just after a posedge. Returns just after the edge that commits
    // the transfer; lat counts cycles from the setup cycle to pready.
    task automatic apb(input logic wr, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wd,
                       output logic [DATA_W-1:0] rd, output logic err,
                       output int lat);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wd;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        lat     = 1;
        @(negedge pclk);
        while (!pready && lat < 8) begin
            @(posedge pclk);
            #1;
            lat++;
            @(negedge pclk);
        end
        rd  = prdata;
        err = pslverr;
        @(posedge pclk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic wr_reg(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] rd;
        logic              err;
        int                lat;
        apb(1'b1, a, d, rd, err, lat);
        check({tag, " latency"}, 32'(lat), 32'd3);
        check({tag, " pslverr"}, 32'(err), 32'd0);
    endtask

    task automatic rd_reg(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
        logic [DATA_W-1:0] rd;
        logic              err;
        int                lat;
        apb(1'b0, a, '0, rd, err, lat);
        check({tag, " latency"}, 32'(lat), 32'd3);
        check({tag, " pslverr"}, 32'(err), 32'd0);
        check({tag, " data"}, 32'(rd), 32'(exp));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [DATA_W-1:0] rd;
        logic              err;
        int                lat;
        int                c0;
        int                t0;

        // Reset for two edges
        presetn = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        presetn = 1'b1;
        @(negedge pclk);
        check("rst pready", 32'(pready), 32'd0);
        check("rst pslverr", 32'(pslverr), 32'd0);
        check("rst prdata", 32'(prdata), 32'd0);
        check("rst irq", 32'(irq), 32'd0);
        check("rst tick", 32'(tick), 32'd0);
        @(posedge pclk);
        #1;
        rd_reg("rst ctrl", 8'h00, 21'h0);
        rd_reg("rst load", 8'h01, 21'h0);
        rd_reg("rst count", 8'h02, 21'h0);
        rd_reg("rst status", 8'h03, 21'h0);

        // One-shot, PRESCALE=0: count event every cycle after the CTRL commit
        wr_reg("os load", 8'h01, 21'd5);
        t0 = tick_cnt;
        wr_reg("os ctrl", 8'h00, 21'h001);
        c0 = cyc;
        rd_reg("os count mid", 8'h02, 21'd3);   // sampled before edge c0+3
        rd_reg("os status", 8'h03, 21'd1);      // expiry at edge c0+6
        rd_reg("os ctrl en off", 8'h00, 21'h000);
        rd_reg("os count end", 8'h02, 21'd0);
        check("os tick count", 32'(tick_cnt - t0), 32'd6);
        check("os irq off", 32'(irq), 32'd0);
        wr_reg("os clear", 8'h03, 21'd1);
        rd_reg("os status cleared", 8'h03, 21'd0);

        // Auto-reload, PRESCALE=3: events at c0+4k, expiries at c0+12k
        wr_reg("ar load", 8'h01, 21'd2);
        wr_reg("ar ctrl", 8'h00, 21'h01F);
        c0 = cyc;
        for (int i = 1; i <= 24; i++) begin
            wait_to(c0 + i);
            @(negedge pclk);
            check("ar tick", 32'(tick), (i % 4 == 0) ? 32'd1 : 32'd0);
            check("ar irq", 32'(irq), (i >= 13) ? 32'd1 : 32'd0);
        end
        wait_to(c0 + 25);
        rd_reg("ar count reload", 8'h02, 21'd2);  // sampled before edge c0+28
        wr_reg("ar clear", 8'h03, 21'd1);         // commits at edge c0+33
        @(negedge pclk);
        check("ar irq lag", 32'(irq), 32'd1);
        wait_to(c0 + 34);
        @(negedge pclk);
        check("ar irq cleared", 32'(irq), 32'd0);

        // Clear committing on the same edge as the expiry at c0+48
        wait_to(c0 + 44);
        wr_reg("col clear", 8'h03, 21'd1);
        @(negedge pclk);
        check("col irq edge", 32'(irq), 32'd1);
        wait_to(c0 + 49);
        @(negedge pclk);
        check("col irq after", 32'(irq), 32'd1);
        wait_to(c0 + 50);
        rd_reg("col status", 8'h03, 21'd1);

        // Stop the timer and clear the flag
        wr_reg("stop ctrl", 8'h00, 21'h000);
        wr_reg("stop clear", 8'h03, 21'd1);
        rd_reg("stop status", 8'h03, 21'd0);
        rd_reg("stop load", 8'h01, 21'd2);

        // Invalid addresses: error response, zero data, no side effects
        apb(1'b0, 8'h04, '0, rd, err, lat);
        check("inv rd latency", 32'(lat), 32'd3);
        check("inv rd pslverr", 32'(err), 32'd1);
        check("inv rd data", 32'(rd), 32'd0);
        apb(1'b1, 8'h04, 21'h0007FF, rd, err, lat);
        check("inv wr latency", 32'(lat), 32'd3);
        check("inv wr pslverr", 32'(err), 32'd1);
        apb(1'b1, 8'h05, 21'h01234, rd, err, lat);
        check("inv wr2 pslverr", 32'(err), 32'd1);
        rd_reg("inv ctrl kept", 8'h00, 21'h000);
        rd_reg("inv load kept", 8'h01, 21'd2);

        // psel dropped during the wait cycle: no pready, no write
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 8'h01;
        pwdata  = 21'h00123;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        @(posedge pclk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            check("abort pready", 32'(pready), 32'd0);
            @(posedge pclk);
            #1;
        end
        rd_reg("abort load kept", 8'h01, 21'd2);

        // COUNT is read-only
        wr_reg("ro load", 8'h01, 21'd7);
        wr_reg("ro count write", 8'h02, 21'h1FFFFF);
        rd_reg("ro count kept", 8'h02, 21'd7);

        // Reset in the wait cycle of a LOAD write while the timer runs
        wr_reg("mr load", 8'h01, 21'd2);
        wr_reg("mr ctrl", 8'h00, 21'h007);
        c0 = cyc;
        wait_to(c0 + 5);
        @(negedge pclk);
        check("mr irq before", 32'(irq), 32'd1);
        wait_to(c0 + 6);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 8'h01;
        pwdata  = 21'h00ABC;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        @(posedge pclk);
        #1;
        presetn = 1'b0;
        @(posedge pclk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        @(negedge pclk);
        check("mr pready", 32'(pready), 32'd0);
        check("mr tick", 32'(tick), 32'd0);
        check("mr irq", 32'(irq), 32'd0);
        check("mr prdata", 32'(prdata), 32'd0);
        @(posedge pclk);
        #1;
        presetn = 1'b1;
        rd_reg("mr ctrl", 8'h00, 21'h0);
        rd_reg("mr load", 8'h01, 21'h0);
        rd_reg("mr count", 8'h02, 21'h0);
        rd_reg("mr status", 8'h03, 21'h0);
        @(negedge pclk);
        check("mr tick after", 32'(tick), 32'd0);
        check("mr irq after", 32'(irq), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/apb_timer_slave.md
Name: apb_timer_slave

Overview:
- APB peripheral slave carrying a programmable prescaled down-counter timer.
- Attaches to the APB master as an additional PSEL target, alongside the watchdog and memory slaves.
- Registers are accessed with one wait state.
- Raises a level interrupt to the CPU on expiry, with optional auto-reload.

Parameters:
- DATA_W, 21, APB data width; matches the existing prdata/pwdata width.
- ADDR_W, 8, APB address width; only paddr[1:0] is decoded.
- PRE_W, 8, prescaler field width.

Ports:
- pclk  in  1  APB clock; the single clock domain.
- presetn  in  1  synchronous, active-low reset, sampled on the rising edge of pclk.
- psel  in  1  slave select from the APB master.
- penable  in  1  APB access phase.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_W  register address.
- pwdata  in  DATA_W  write data.
- prdata  out  DATA_W  read data; valid while pready=1.
- pready  out  1  transfer complete; high for exactly one cycle per transfer.
- pslverr  out  1  error response; valid only with pready.
- irq  out  1  interrupt = STATUS.EXPIRED & CTRL.IRQ_EN.
- tick  out  1  one-cycle pulse on each prescaled count event (debug/observability).

Behaviour:
- Reset (presetn=0 at a pclk edge) clears the following to 0: all registers, the prescale counter, COUNT, the FSM (to IDLE), prdata, pready, pslverr, irq and tick.
- Register map (paddr[1:0]):
  - 0 CTRL: [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN, [10:3] PRESCALE; upper bits read 0.
  - 1 LOAD: full DATA_W reload value.
  - 2 COUNT: read-only; writes are accepted with pready but ignored.
  - 3 STATUS: [0] EXPIRED, sticky; writing 1 to bit 0 clears it.
- paddr[ADDR_W-1:2] != 0 is an invalid address: pready=1, pslverr=1, write ignored, prdata=0.
- APB FSM:
  - IDLE -> SETUP when psel=1 and penable=0.
  - SETUP -> WAIT when psel=1 and penable=1.
  - WAIT -> DONE unconditionally; this is the single wait state.
  - DONE: pready=1 for one cycle, write committed at the end of this cycle, prdata driven; then -> IDLE.
- psel dropping in SETUP or WAIT aborts the transfer: -> IDLE, no write, no pready.
- prdata holds its last value outside DONE; pslverr is 0 outside DONE.
- Transfer latency: pready goes high on the 3rd cycle after the setup-phase cycle.
- Prescaler:
  - When EN=1, the prescale counter increments every pclk.
  - When it equals PRESCALE: tick=1 and the prescale counter resets to 0.
  - One count event occurs every PRESCALE+1 cycles; PRESCALE=0 gives a count event every cycle.
- Count event:
  - COUNT>0: COUNT decrements by 1.
  - COUNT==0: EXPIRED is set. If AUTO_RELOAD=1, COUNT is reloaded from LOAD; otherwise EN is cleared and COUNT stays 0.
- COUNT load rules:
  - A CTRL write with EN going 0->1 loads COUNT from LOAD and clears the prescale counter.
  - A LOAD write while EN=0 also updates COUNT.
  - A LOAD write while EN=1 affects only the next reload.
- EN cleared by software freezes COUNT and the prescaler; no expiry occurs while EN=0.
- A STATUS clear that coincides with an expiry in the same cycle: expiry wins, so EXPIRED stays 1.
- A CTRL write that coincides with an auto-disable on expiry: the software-written value wins.
- irq is registered and follows STATUS/CTRL with one cycle of latency.
- Reset asserted mid-transfer: the FSM returns to IDLE, pready=0, and the partial write is lost.

Test Plan:
- Reset check: hold presetn=0 for 2 cycles, then read CTRL, LOAD, COUNT and STATUS -> each returns 0 with pslverr=0; pready is seen exactly 3 cycles after each setup phase.
- One-shot: write LOAD=5, then CTRL=0x001 (EN=1, PRESCALE=0).
  - COUNT steps 5,4,3,2,1,0 over 6 cycles.
  - On the next count event EXPIRED=1 and EN=0.
  - irq stays 0 because IRQ_EN=0.
- Auto-reload with prescaler: LOAD=2, CTRL=EN|AUTO_RELOAD|IRQ_EN|PRESCALE=3 (0x01F).
  - tick fires every 4 cycles.
  - Expiry occurs every 12 cycles and COUNT reloads to 2.
  - irq=1 one cycle after the first expiry; a STATUS write of 1 drops irq to 0.
- Clear/expiry collision: time the STATUS write-1 so its DONE cycle coincides with an expiry event -> EXPIRED remains 1 and irq stays high.
- Protocol errors:
  - Access to paddr=0x04 -> pslverr=1, prdata=0, no register changes.
  - Transfer with psel dropped during WAIT -> no pready, no write.
  - Write of 0x1FFFFF to COUNT -> COUNT unchanged.
- Mid-operation reset: assert presetn=0 during WAIT of a LOAD write of 0x00ABC and while the timer is running -> all registers are 0 afterwards, LOAD is not updated, and tick/irq are 0.
